combo_lock_core: RTL and testbench

//  Parametrised combination-lock engine: digit select (up/down wrap), digit shift-in, compare, lock/unlock FSM.

---
 rtl/combo_lock_core.sv | 216 +++++++++++++++++++++
 tb/tb_combo_lock_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_core.sv
// combo_lock_core: combination-lock engine with digit select, shift-in entry,
// compare, lock/unlock FSM, failed-attempt counter and timed lockout.
// Optional feature macro: CODE_PROG_EN (when defined, a completing entry
// while UNLOCKED reprograms the combination and pulses code_saved).
module combo_lock_core #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inc,
  input  logic                               dec,
  input  logic                               enter,
  input  logic                               clr,
  input  logic                               lock,
  output logic [DIGIT_W-1:0]                 sel_digit,
  output logic [DIGITS*DIGIT_W-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]        count,
  output logic [1:0]                         state,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
  output logic                               code_saved
);

  localparam int EW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);

  localparam logic [1:0] ST_LOCKED   = 2'b00;
  localparam logic [1:0] ST_UNLOCKED = 2'b01;
  localparam logic [1:0] ST_LOCKOUT  = 2'b10;

  localparam logic [CW-1:0] LAST_POS   = CW'(DIGITS - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [DIGIT_W-1:0] sel_q, sel_d;
  logic [EW-1:0]      entry_q, entry_d;
  logic [CW-1:0]      count_q, count_d;
  logic [FW-1:0]      fail_q, fail_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [EW-1:0]      code_s;
  logic [EW-1:0]      cand_s;
  logic               completing_s;
  logic               abandon_s;
  logic               match_s;
  logic               last_fail_s;

`ifdef CODE_PROG_EN
  logic [EW-1:0]      code_q, code_d;
  logic               saved_q, saved_d;
  assign code_s     = code_q;
  assign code_saved = saved_q;
`else
  assign code_s     = DEFAULT_CODE;
  assign code_saved = 1'b0;
`endif

  // The shifted entry doubles as the candidate when the last digit goes in.
  assign cand_s       = {entry_q[EW-DIGIT_W-1:0], sel_q};
  assign completing_s = enter && (count_q == LAST_POS);
  assign abandon_s    = clr || lock;
  assign match_s      = (cand_s == code_s);
  assign last_fail_s  = (fail_q == (FAIL_MAX - FW'(1)));

  assign sel_digit = sel_q;
  assign entry     = entry_q;
  assign count     = count_q;
  assign state     = state_q;
  assign fail_cnt  = fail_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abandon (clr/lock) beats a completing enter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCKED: begin
        if (!abandon_s && completing_s) begin
          if (match_s) begin
            state_d = ST_UNLOCKED;
          end else if (last_fail_s) begin
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (lock) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  // Datapath next values: digit select, entry shift, fail counter, lockout timer, code.
  always_comb begin
    sel_d   = sel_q;
    entry_d = entry_q;
    count_d = count_q;
    fail_d  = fail_q;
    timer_d = timer_q;
`ifdef CODE_PROG_EN
    code_d  = code_q;
    saved_d = 1'b0;
`endif
    case (state_q)
      ST_LOCKED, ST_UNLOCKED: begin
        if (abandon_s) begin
          entry_d = '0;
          count_d = '0;
          // A relock from UNLOCKED keeps the selected digit; clr always zeroes it.
          if (clr || (state_q == ST_LOCKED)) begin
            sel_d = '0;
          end else begin
            sel_d = sel_q;
          end
        end else if (enter) begin
          if (completing_s) begin
            entry_d = '0;
            count_d = '0;
            if (state_q == ST_LOCKED) begin
              if (match_s) begin
                fail_d = '0;
              end else if (fail_q != FAIL_MAX) begin
                fail_d = fail_q + FW'(1);
                if (last_fail_s) begin
                  timer_d = TIMER_LOAD;
                end else begin
                  timer_d = timer_q;
                end
              end else begin
                fail_d = fail_q;
              end
            end else begin
`ifdef CODE_PROG_EN
              code_d  = cand_s;
              saved_d = 1'b1;
`endif
            end
          end else begin
            entry_d = cand_s;
            count_d = count_q + CW'(1);
          end
        end else if (inc && !dec) begin
          sel_d = sel_q + DIGIT_W'(1);
        end else if (dec && !inc) begin
          sel_d = sel_q - DIGIT_W'(1);
        end else begin
          sel_d = sel_q;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d = '0;
          sel_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      entry_q <= '0;
      count_q <= '0;
      fail_q  <= '0;
      timer_q <= '0;
`ifdef CODE_PROG_EN
      code_q  <= DEFAULT_CODE;
      saved_q <= 1'b0;
`endif
    end else begin
      sel_q   <= sel_d;
      entry_q <= entry_d;
      count_q <= count_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
`ifdef CODE_PROG_EN
      code_q  <= code_d;
      saved_q <= saved_d;
`endif
    end
  end

endmodule

// File: tb/tb_combo_lock_core.sv
// Self-checking bench for combo_lock_core: directed scenarios plus randomized
// traffic against a queue-based behavioural model of the lock.
module tb_combo_lock_core;

  localparam int LOCK_CYC = 16;
  localparam int MAXF     = 3;

  logic        clk = 1'b0;
  logic        rst, inc, dec, enter, clr, lock;
  logic [3:0]  sel_digit;
  logic [15:0] entry;
  logic [2:0]  count;
  logic [1:0]  state;
  logic [1:0]  fail_cnt;
  logic        code_saved;

  combo_lock_core #(
    .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234),
    .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .enter(enter), .clr(clr),
    .lock(lock), .sel_digit(sel_digit), .entry(entry), .count(count),
    .state(state), .fail_cnt(fail_cnt), .code_saved(code_saved)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 LOCKED, 1 UNLOCKED, 2 LOCKOUT
  int m_sel, m_state, m_fails, m_left, m_code, m_saved;
  int m_digits[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_sel = 0; m_state = 0; m_fails = 0; m_left = 0; m_code = 'h1234; m_saved = 0;
    m_digits.delete();
  endtask

  function automatic int model_entry();
    int e = 0;
    foreach (m_digits[k]) e = e * 16 + m_digits[k];
    return e;
  endfunction

  task automatic model_step(input bit i, input bit d, input bit e, input bit c, input bit l);
    int cand;
    m_saved = 0;
    if (m_state == 2) begin
      m_left--;
      if (m_left == 0) begin m_state = 0; m_fails = 0; m_sel = 0; end
    end else if (c || l) begin
      m_digits.delete();
      if (c || m_state == 0) m_sel = 0;
      if (l) m_state = 0;
    end else if (e) begin
      if (m_digits.size() == 3) begin
        cand = model_entry() * 16 + m_sel;
        m_digits.delete();
        if (m_state == 0) begin
          if (cand == m_code) begin m_state = 1; m_fails = 0; end
          else begin
            m_fails++;
            if (m_fails == MAXF) begin m_state = 2; m_left = LOCK_CYC; end
          end
        end else begin
`ifdef CODE_PROG_EN
          m_code = cand; m_saved = 1;
`endif
        end
      end else begin
        m_digits.push_back(m_sel);
      end
    end else if (i && !d) m_sel = (m_sel + 1) % 16;
    else if (d && !i) m_sel = (m_sel + 15) % 16;
  endtask

  task automatic compare_all();
    check_eq("sel_digit", sel_digit, m_sel);
    check_eq("entry", entry, model_entry());
    check_eq("count", count, m_digits.size());
    check_eq("state", state, m_state);
    check_eq("fail_cnt", fail_cnt, m_fails);
    check_eq("code_saved", code_saved, m_saved);
  endtask

  task automatic do_cycle(input bit i, input bit d, input bit e, input bit c, input bit l);
    inc = i; dec = d; enter = e; clr = c; lock = l;
    @(posedge clk); #1;
    inc = 1'b0; dec = 1'b0; enter = 1'b0; clr = 1'b0; lock = 1'b0;
    model_step(i, d, e, c, l);
    compare_all();
  endtask

  task automatic press_digit(input int dg);
    int guard = 0;
    while (m_sel != dg && guard < 20) begin
      if (((dg - m_sel + 16) % 16) <= 8) do_cycle(1, 0, 0, 0, 0);
      else do_cycle(0, 1, 0, 0, 0);
      guard++;
    end
    do_cycle(0, 0, 1, 0, 0);
  endtask

  task automatic enter_code(input int c);
    for (int k = 0; k < 4; k++) press_digit((c >> (4 * (3 - k))) & 15);
  endtask

  task automatic random_cycle();
    int op = $urandom_range(0, 11);
    case (op)
      0: do_cycle(1, 0, 0, 0, 0);
      1: do_cycle(0, 1, 0, 0, 0);
      2: do_cycle(1, 1, 0, 0, 0);
      3: do_cycle(0, 0, 1, 0, 0);
      4: do_cycle(1, 0, 1, 0, 0);
      5: do_cycle(0, 1, 1, 0, 0);
      6: do_cycle(0, 0, 0, 1, 0);
      7: do_cycle(1, 0, 1, 1, 0);
      8: do_cycle(0, 0, 0, 0, 1);
      9: do_cycle(0, 0, 1, 0, 1);
      default: do_cycle(0, 0, 0, 0, 0);
    endcase
  endtask

  task automatic async_reset();
    rst = 1'b1; #2;
    model_reset();
    compare_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inc = 1'b0; dec = 1'b0; enter = 1'b0; clr = 1'b0; lock = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    check_eq("rst_state", state, 2'b00);
    rst = 1'b0;

    // Digit select wrap and inc+dec cancellation
    do_cycle(0, 1, 0, 0, 0); check_eq("t1_dec_wrap", sel_digit, 4'hF);
    do_cycle(1, 0, 0, 0, 0); check_eq("t1_inc_wrap", sel_digit, 4'h0);
    do_cycle(1, 1, 0, 0, 0); check_eq("t1_inc_dec", sel_digit, 4'h0);

    // Correct code unlocks
    press_digit(1); press_digit(2); press_digit(3);
    check_eq("t2_entry", entry, 16'h0123);
    check_eq("t2_count", count, 3'd3);
    press_digit(4);
    check_eq("t2_unlocked", state, 2'b01);
    check_eq("t2_entry_clr", entry, 16'h0000);
    do_cycle(0, 0, 0, 0, 1);
    check_eq("t2_relock", state, 2'b00);

    // Three wrong codes, lockout of exactly LOCK_CYC cycles
    enter_code('h1235); check_eq("t3_fail1", fail_cnt, 2'd1);
    enter_code('h1235); check_eq("t3_fail2", fail_cnt, 2'd2);
    enter_code('h1235); check_eq("t3_lockout", state, 2'b10);
    for (int k = 1; k <= LOCK_CYC; k++) begin
      random_cycle();
      if (k < LOCK_CYC) check_eq("t3_in_lockout", state, 2'b10);
      else begin
        check_eq("t3_lockout_end", state, 2'b00);
        check_eq("t3_fail_zero", fail_cnt, 2'd0);
      end
    end

    // Two wrong, then right
    enter_code('h1235); enter_code('h1235);
    enter_code('h1234);
    check_eq("t4_unlock", state, 2'b01);
    check_eq("t4_fail_zero", fail_cnt, 2'd0);
    do_cycle(0, 0, 0, 0, 1);
    check_eq("t4_lock", state, 2'b00);

    // clr mid-entry, reset mid-lockout
    press_digit(1); press_digit(2);
    do_cycle(0, 0, 0, 1, 0);
    check_eq("t5_clr_entry", entry, 16'h0000);
    check_eq("t5_clr_sel", sel_digit, 4'h0);
    enter_code('h1111); enter_code('h1111); enter_code('h1111);
    check_eq("t5_lockout", state, 2'b10);
    repeat (3) do_cycle(0, 0, 0, 0, 0);
    async_reset();
    check_eq("t5_rst_state", state, 2'b00);

    // Code programming (or its absence)
    enter_code('h1234);
    check_eq("t6_unlock", state, 2'b01);
    enter_code('h9876);
`ifdef CODE_PROG_EN
    check_eq("t6_saved", code_saved, 1'b1);
`else
    check_eq("t6_saved", code_saved, 1'b0);
`endif
    check_eq("t6_still_unlocked", state, 2'b01);
    do_cycle(0, 0, 0, 0, 1);
    enter_code('h1234);
`ifdef CODE_PROG_EN
    check_eq("t6_old_fails", state, 2'b00);
    enter_code('h9876);
    check_eq("t6_new_unlocks", state, 2'b01);
`else
    check_eq("t6_default_unlocks", state, 2'b01);
`endif
    async_reset();

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 10) enter_code(m_code);
      else if (r < 18) enter_code($urandom_range(0, 65535));
      else if (r < 19) async_reset();
      else random_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
